// File: rtl/combat_pkg.sv
// combat_pkg: shared saber state encoding, coordinate widths and an abs-difference helper.
package combat_pkg;
  localparam int X_W = 12;
  localparam int Y_W = 11;
  localparam int HP_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, BLOCK = 2'd2, COOLDOWN = 2'd3} saber_state_t;
  function automatic logic [X_W-1:0] absd(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/saber_speed.sv
// saber_speed: per-frame position and |dx|+|dy| speed; SABER_SMOOTH_EN enables 2-tap position averaging.
module saber_speed
  import combat_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           nf_in,
  input  logic           valid_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic [12:0]    spd,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [X_W-1:0] prev_x,
  output logic [Y_W-1:0] prev_y
);
  logic first_q;
  logic [X_W-1:0] dx;
  logic [X_W-1:0] dy;
`ifdef SABER_SMOOTH_EN
  logic [X_W-1:0] raw_x_q;
  logic [Y_W-1:0] raw_y_q;
  logic [X_W:0] sum_x;
  logic [Y_W:0] sum_y;
  assign sum_x = {1'b0, x_in} + {1'b0, raw_x_q};
  assign sum_y = {1'b0, y_in} + {1'b0, raw_y_q};
  assign pos_x = first_q ? x_in : sum_x[X_W:1];
  assign pos_y = first_q ? y_in : sum_y[Y_W:1];
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      raw_x_q <= '0;
      raw_y_q <= '0;
    end else if (nf_in && valid_in) begin
      raw_x_q <= x_in;
      raw_y_q <= y_in;
    end
  end
`else
  assign pos_x = x_in;
  assign pos_y = y_in;
`endif
  assign dx = absd(pos_x, prev_x);
  assign dy = absd({1'b0, pos_y}, {1'b0, prev_y});
  assign spd = (first_q || !valid_in) ? 13'd0 : {1'b0, dx} + {1'b0, dy};
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      first_q <= 1'b1;
      prev_x <= '0;
      prev_y <= '0;
    end else if (nf_in) begin
      first_q <= 1'b0;
      if (valid_in) begin
        prev_x <= pos_x;
        prev_y <= pos_y;
      end
    end
  end
endmodule

// File: rtl/saber_combat_fsm.sv
// saber_combat_fsm: per-frame saber combat engine (state, attack origin, opponent health, game over).
// Build option SABER_SMOOTH_EN (in saber_speed) averages consecutive positions.
module saber_combat_fsm
  import combat_pkg::*;
#(
  parameter int SWING_THRESH    = 30,
  parameter int STILL_THRESH    = 4,
  parameter int BLOCK_HOLD      = 8,
  parameter int ATTACK_FRAMES   = 12,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int MAX_HEALTH      = 5
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            nf_in,
  input  logic            saber_valid_in,
  input  logic [X_W-1:0]  saber_x_in,
  input  logic [Y_W-1:0]  saber_y_in,
  input  logic [X_W-1:0]  opp_box_x_in,
  input  logic [Y_W-1:0]  opp_box_y_in,
  input  logic [X_W-1:0]  opp_box_xmax_in,
  input  logic [Y_W-1:0]  opp_box_ymax_in,
  input  logic [1:0]      opp_state_in,
  output logic [1:0]      saber_state_out,
  output logic [X_W-1:0]  attack_x_out,
  output logic [Y_W-1:0]  attack_y_out,
  output logic [HP_W-1:0] opp_health_out,
  output logic            hit_out,
  output logic            game_over_out
);
  saber_state_t state;
  logic [7:0] cnt;
  logic [12:0] spd;
  logic [X_W-1:0] pos_x, prev_x;
  logic [Y_W-1:0] pos_y, prev_y;
  logic swing, still, atk_end, hit, last_hp;
  saber_speed u_speed (
    .clk_in(clk_in), .rst_in(rst_in), .nf_in(nf_in), .valid_in(saber_valid_in),
    .x_in(saber_x_in), .y_in(saber_y_in), .spd(spd), .pos_x(pos_x), .pos_y(pos_y),
    .prev_x(prev_x), .prev_y(prev_y)
  );
  assign swing = spd >= 13'(SWING_THRESH);
  assign still = saber_valid_in && (spd < 13'(STILL_THRESH));
  assign atk_end = !swing || (cnt == 8'(ATTACK_FRAMES - 1));
  assign hit = (pos_x >= opp_box_x_in) && (pos_x <= opp_box_xmax_in) &&
               (pos_y >= opp_box_y_in) && (pos_y <= opp_box_ymax_in) && (opp_state_in != 2'd2);
  assign last_hp = opp_health_out == HP_W'(1);
  assign saber_state_out = state;
  // cnt is reused per state: still run in IDLE, frames in ATTACK, frames in COOLDOWN.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      cnt <= '0;
      attack_x_out <= '0;
      attack_y_out <= '0;
      opp_health_out <= HP_W'(MAX_HEALTH);
      hit_out <= 1'b0;
      game_over_out <= 1'b0;
    end else begin
      hit_out <= 1'b0;
      if (nf_in && !game_over_out) begin
        if ((state == IDLE || state == BLOCK) && swing) begin
          state <= ATTACK;
          cnt <= '0;
          attack_x_out <= prev_x;
          attack_y_out <= prev_y;
        end else begin
          case (state)
            IDLE: begin
              state <= (still && cnt == 8'(BLOCK_HOLD - 1)) ? BLOCK : IDLE;
              cnt <= (still && cnt != 8'(BLOCK_HOLD - 1)) ? cnt + 8'd1 : '0;
            end
            BLOCK: begin
              state <= saber_valid_in ? BLOCK : IDLE;
              cnt <= '0;
            end
            ATTACK: begin
              cnt <= atk_end ? '0 : cnt + 8'd1;
              if (atk_end) begin
                state <= (hit && last_hp) ? IDLE : COOLDOWN;
                if (hit && opp_health_out != '0) begin
                  hit_out <= 1'b1;
                  opp_health_out <= opp_health_out - HP_W'(1);
                  game_over_out <= last_hp;
                end
              end
            end
            COOLDOWN: begin
              state <= (cnt == 8'(COOLDOWN_FRAMES - 1)) ? IDLE : COOLDOWN;
              cnt <= (cnt == 8'(COOLDOWN_FRAMES - 1)) ? '0 : cnt + 8'd1;
            end
          endcase
        end
      end
    end
  end
endmodule
